// File: rtl/regbank_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wb_arbiter
// Round-robin write-back arbiter in front of a 32-entry register bank, with a
// pending-write scoreboard that stalls WAW issues and flags source registers
// that are not yet valid in the bank.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/dir/data : NREQ write-back requesters (dir 5b, data DW each)
//   req_ready          : one-hot (or zero) grant, combinational
//   wr_en/dir/data     : registered bank write port (WriteFlag/DirW/WriteData)
//   issue_valid/dir    : issuing instruction that will write issue_dir
//   issue_ready        : low while issue_dir already has a write outstanding
//   chk_a/chk_b        : source registers being read (DirA/DirB)
//   busy_a/busy_b      : source register not yet valid in the bank
//   pending            : scoreboard, bit r = write to register r outstanding
//   err                : sticky, a write-back hit a non-pending register
// ---------------------------------------------------------------------------
module regbank_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*5-1:0]  req_dir,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wr_en,
    output logic [4:0]         wr_dir,
    output logic [DW-1:0]      wr_data,
    input  logic               issue_valid,
    input  logic [4:0]         issue_dir,
    output logic               issue_ready,
    input  logic [4:0]         chk_a,
    input  logic [4:0]         chk_b,
    output logic               busy_a,
    output logic               busy_b,
    output logic [31:0]        pending,
    output logic               err
);

    // Pointer / select width; NREQ is limited to 2..4.
    localparam int SW = (NREQ > 2) ? 2 : 1;

    logic [SW-1:0] r_rr;
    logic          r_wr_en;
    logic [4:0]    r_wr_dir;
    logic [DW-1:0] r_wr_data;
    logic [31:0]   r_pending;
    logic          r_err;

    logic [4:0]    w_dir_arr  [NREQ];
    logic [DW-1:0] w_data_arr [NREQ];
    logic [2:0]    w_cand;
    logic [SW-1:0] w_sel;
    logic          w_found;
    logic          w_xfer;
    logic          w_issue;
    logic          w_err_hit;
    logic [4:0]    w_wb_dir;
    logic [DW-1:0] w_wb_data;
    logic [31:0]   w_pending_nxt;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_dir_arr[g]  = req_dir[5*g +: 5];
        assign w_data_arr[g] = req_data[DW*g +: DW];
    end

    // Scan requesters starting at the round-robin pointer; the first valid
    // one wins. rr + k is below 2*NREQ, so one subtraction wraps it.
    always_comb begin
        w_cand  = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = 3'(r_rr) + 3'(k);
            if (w_cand >= 3'(NREQ)) w_cand = w_cand - 3'(NREQ);
            if (!w_found && req_valid[w_cand[SW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[SW-1:0];
            end
        end
    end

    assign w_xfer    = w_found & ~rst;
    assign req_ready = w_xfer ? (NREQ'(1) << w_sel) : '0;
    assign w_wb_dir  = w_dir_arr[w_sel];
    assign w_wb_data = w_data_arr[w_sel];

    assign issue_ready = ~r_pending[issue_dir] & ~rst;
    assign w_issue     = issue_valid & issue_ready;
    assign w_err_hit   = w_xfer & ~r_pending[w_wb_dir];

    // Clear for the completing write first, then set for the new issue; the
    // two can only collide on a register that was not pending (err case),
    // where the newer issue must stay tracked.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_xfer)  w_pending_nxt[w_wb_dir]  = 1'b0;
        if (w_issue) w_pending_nxt[issue_dir] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_dir  <= '0;
            r_wr_data <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_rr      <= (w_sel == SW'(NREQ-1)) ? '0 : w_sel + SW'(1);
                r_wr_en   <= 1'b1;
                r_wr_dir  <= w_wb_dir;
                r_wr_data <= w_wb_data;
            end else begin
                r_wr_en   <= 1'b0;
            end
            r_pending <= w_pending_nxt;
            if (w_err_hit) r_err <= 1'b1;
        end
    end

    // The bank write lands at the end of the wr_en cycle, so a register being
    // written right now is still stale for a same-cycle read.
    assign busy_a = r_pending[chk_a] | (r_wr_en & (r_wr_dir == chk_a));
    assign busy_b = r_pending[chk_b] | (r_wr_en & (r_wr_dir == chk_b));

    assign wr_en   = r_wr_en;
    assign wr_dir  = r_wr_dir;
    assign wr_data = r_wr_data;
    assign pending = r_pending;
    assign err     = r_err;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
module tb_regbank_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_dir;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [4:0]         wr_dir;
    logic [DW-1:0]      wr_data;
    logic               issue_valid;
    logic [4:0]         issue_dir;
    logic               issue_ready;
    logic [4:0]         chk_a, chk_b;
    logic               busy_a, busy_b;
    logic [31:0]        pending;
    logic               err;

    int checks = 0;
    int errors = 0;
    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    regbank_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dir(req_dir), .req_data(req_data),
        .req_ready(req_ready),
        .wr_en(wr_en), .wr_dir(wr_dir), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_dir(issue_dir), .issue_ready(issue_ready),
        .chk_a(chk_a), .chk_b(chk_b), .busy_a(busy_a), .busy_b(busy_b),
        .pending(pending), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive requester i and record the write it is expected to produce.
    task automatic drive_req(input int i, input logic [4:0] d, input logic [31:0] v, input bit expect_wr);
        req_valid[i]        = 1'b1;
        req_dir[5*i +: 5]   = d;
        req_data[DW*i +: DW] = v;
        if (expect_wr) sb_q.push_back({d, v});
    endtask

    // Every bank write must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {27'd0, wr_dir}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                chk("wb_dir", {27'd0, wr_dir}, {27'd0, e[36:32]});
                chk("wb_data", wr_data, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_dir = '0; req_data = '0;
        issue_valid = 1'b0; issue_dir = '0; chk_a = '0; chk_b = '0;
        tick(); tick();

        // Reset state; nothing accepted while rst is high.
        chk("rst_pending", pending, 32'h0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_dir", {27'd0, wr_dir}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        req_valid = 3'b111; issue_valid = 1'b1; issue_dir = 5'd4;
        #1;
        chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
        tick();
        chk("rst_no_issue", pending, 32'h0);
        req_valid = '0; issue_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Issue to register 5.
        issue_valid = 1'b1; issue_dir = 5'd5; chk_a = 5'd5; chk_b = 5'd6;
        #1;
        chk("issue_ready5", {31'd0, issue_ready}, 32'd1);
        tick();
        chk("pending5", pending, 32'h0000_0020);
        chk("issue_stall5", {31'd0, issue_ready}, 32'd0);
        chk("busy_a5", {31'd0, busy_a}, 32'd1);
        chk("busy_b6", {31'd0, busy_b}, 32'd0);

        // Make 10..13 pending.
        for (int r = 10; r < 14; r++) begin
            issue_dir = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        chk("pending_multi", pending, 32'h0000_3C20);

        // All three requesters held: grants rotate 0,1,2,0.
        drive_req(0, 5'd10, 32'hA000_0000, 1'b1);
        drive_req(1, 5'd11, 32'hA000_0001, 1'b0);
        drive_req(2, 5'd12, 32'hA000_0002, 1'b0);
        #1;
        chk("rr_g0", {29'd0, req_ready}, 32'b001);
        tick();
        chk("rr_wr1", {31'd0, wr_en}, 32'd1);
        sb_q.push_back({5'd11, 32'hA000_0001});
        drive_req(0, 5'd13, 32'hA000_0003, 1'b0);
        #1;
        chk("rr_g1", {29'd0, req_ready}, 32'b010);
        tick();
        chk("rr_wr2", {31'd0, wr_en}, 32'd1);
        sb_q.push_back({5'd12, 32'hA000_0002});
        #1;
        chk("rr_g2", {29'd0, req_ready}, 32'b100);
        tick();
        chk("rr_wr3", {31'd0, wr_en}, 32'd1);
        sb_q.push_back({5'd13, 32'hA000_0003});
        #1;
        chk("rr_g3", {29'd0, req_ready}, 32'b001);
        tick();
        chk("rr_wr4", {31'd0, wr_en}, 32'd1);
        req_valid = '0;
        chk("rr_pending", pending, 32'h0000_0020);
        chk("rr_err", {31'd0, err}, 32'd0);
        tick();

        // Requester 1 completes register 5 (rr now 1).
        drive_req(1, 5'd5, 32'hDEAD_BEEF, 1'b1);
        chk_a = 5'd5;
        #1;
        chk("wb5_grant", {29'd0, req_ready}, 32'b010);
        tick();
        req_valid = '0;
        chk("wb5_wr_en", {31'd0, wr_en}, 32'd1);
        chk("wb5_wr_dir", {27'd0, wr_dir}, 32'd5);
        chk("wb5_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("wb5_pending", pending, 32'h0);
        chk("wb5_busy_inflight", {31'd0, busy_a}, 32'd1);
        tick();
        chk("wb5_busy_clear", {31'd0, busy_a}, 32'd0);
        chk("wb5_idle", {31'd0, wr_en}, 32'd0);
        chk("wb5_hold_dir", {27'd0, wr_dir}, 32'd5);
        chk("wb5_hold_data", wr_data, 32'hDEAD_BEEF);

        // Same edge: issue 7 while register 3 completes (rr now 2, only req 0 valid).
        issue_valid = 1'b1; issue_dir = 5'd3;
        tick();
        issue_dir = 5'd7;
        drive_req(0, 5'd3, 32'h0000_0333, 1'b1);
        #1;
        chk("same_issue_rdy", {31'd0, issue_ready}, 32'd1);
        chk("same_grant", {29'd0, req_ready}, 32'b001);
        tick();
        issue_valid = 1'b0; req_valid = '0;
        chk("same_pending", pending, 32'h0000_0080);
        chk("same_err", {31'd0, err}, 32'd0);

        // Write-back to non-pending register 9 (rr now 1, only req 2 valid).
        drive_req(2, 5'd9, 32'h1234_5678, 1'b1);
        #1;
        chk("err_grant", {29'd0, req_ready}, 32'b100);
        tick();
        req_valid = '0;
        chk("err_set", {31'd0, err}, 32'd1);
        tick(); tick();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Transfer accepted, then reset on the following edge (rr now 0).
        issue_valid = 1'b1; issue_dir = 5'd20;
        drive_req(0, 5'd7, 32'h7777_7777, 1'b1);
        tick();
        issue_valid = 1'b0; req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mid_rst_pending", pending, 32'h0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_wr_dir", {27'd0, wr_dir}, 32'd0);
        req_valid = 3'b011;
        #1;
        chk("mid_rst_rr", {29'd0, req_ready}, 32'b001);
        req_valid = '0;
        tick(); tick();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, number of write-back requesters (fixed range 2..4).
REQ-002 The block SHALL have parameter DW, default 32, register data width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester write-back request.
REQ-006 The block SHALL have port req_dir  input  NREQ*5  destination register, requester i at bits [5i+4:5i].
REQ-007 The block SHALL have port req_data  input  NREQ*DW  write data, requester i at bits [DW*i+DW-1:DW*i].
REQ-008 The block SHALL have port req_ready  output  NREQ  grant, one-hot or zero.
REQ-009 The block SHALL have port wr_en  output  1  register-bank write enable, drives bank WriteFlag.
REQ-010 The block SHALL have port wr_dir  output  5  register-bank write address, drives bank DirW.
REQ-011 The block SHALL have port wr_data  output  DW  register-bank write data, drives bank WriteData.
REQ-012 The block SHALL have port issue_valid  input  1  issue of an instruction that will write issue_dir.
REQ-013 The block SHALL have port issue_dir  input  5  destination register of issuing instruction.
REQ-014 The block SHALL have port issue_ready  output  1  issue accepted when issue_valid & issue_ready.
REQ-015 The block SHALL have ports chk_a, chk_b  input  5 each  source registers being read (bank DirA/DirB).
REQ-016 The block SHALL have ports busy_a, busy_b  output  1 each  source register not yet valid in bank.
REQ-017 The block SHALL have port pending  output  32  scoreboard, bit r = write to register r outstanding.
REQ-018 The block SHALL have port err  output  1  sticky: write-back accepted for a non-pending register.

Function
REQ-019 Arbitration SHALL be round-robin over requesters with req_valid=1, searching from pointer rr upward, modulo NREQ.
REQ-020 req_ready SHALL be combinational, at most one bit set, and only for the selected valid requester; all zero when no request or rst=1.
REQ-021 A transfer SHALL occur on an edge where req_valid[i] & req_ready[i]; after it rr SHALL become (i+1) mod NREQ; rr SHALL remain unchanged on cycles without a transfer.
REQ-022 On a transfer from requester i, the next cycle SHALL have wr_en=1, wr_dir=req_dir[i], wr_data=req_data[i] (latency 1, registered outputs); on cycles with no transfer wr_en SHALL be 0 and wr_dir/wr_data SHALL hold.
REQ-023 Sustained throughput SHALL be one write per cycle; a requester held valid with no competition SHALL be granted every cycle.
REQ-024 issue_ready SHALL equal !pending[issue_dir] & !rst (WAW stall); an accepted issue SHALL set pending[issue_dir] at that edge.
REQ-025 A write-back transfer SHALL clear pending[req_dir[i]] at the transfer edge.
REQ-026 Simultaneous accepted issue and write-back transfer to different registers SHALL both take effect; the same register cannot be both, because issue_ready is 0 while it is pending.
REQ-027 busy_a SHALL equal pending[chk_a] | (wr_en & wr_dir==chk_a), and busy_b likewise for chk_b, covering the one-cycle in-flight bank write.
REQ-028 A transfer to a register whose pending bit is 0 SHALL still be performed and SHALL set err=1 until reset.
REQ-029 Register 0 SHALL receive no special treatment: it is tracked and written like any other register.

Reset
REQ-030 With rst=1 at an edge: pending=0, rr=0, wr_en=0, wr_dir=0, wr_data=0, err=0.
REQ-031 Reset mid-operation SHALL discard any accepted-but-unwritten transfer (wr_en=0 on the cycle after reset), and no issue or transfer SHALL be accepted while rst=1.

Verification
REQ-032 Reset, then issue_dir=5 -> pending=0x00000020, issue_ready for dir 5 then 0, busy_a=1 when chk_a=5.
REQ-033 req_valid=3'b111 held, all pending -> grants 0,1,2,0 on consecutive cycles; wr_en=1 every cycle from cycle 2.
REQ-034 Requester 1 writes dir 5 with data 0xDEADBEEF -> next cycle wr_en=1, wr_dir=5, wr_data=0xDEADBEEF, pending[5]=0, busy_a=1 (in flight); following cycle busy_a=0.
REQ-035 Same edge: issue dir 7 and write-back dir 3 (pending) -> pending[7]=1, pending[3]=0.
REQ-036 Write-back to non-pending dir 9 -> write performed, err=1 and held until rst.
REQ-037 Transfer accepted, rst asserted next edge -> wr_en=0, pending=0, rr=0, err=0.
